bridge_arbiter: RTL and testbench

- Two-master arbiter placed in front of the system bridge.
- Shares the single bridge port (address, write data, write enable, byte enables, read data) between master 0 (CPU data port) and master 1 (DMA/debug master).
- Each granted access is latched and issued to the bridge for exactly one cycle. The master then gets a one-cycle ack carrying registered read data.
- Arbitration is round-robin by default; fixed priority is available as a compile option.

---
 rtl/bridge_arbiter_pkg.sv | 13 +
 rtl/arb_rr2.sv | 25 ++
 rtl/bridge_arbiter.sv | 121 ++++++++++++
 tb/tb_bridge_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_arbiter_pkg.sv
// Shared encodings for the two-master bridge arbiter: FSM states and owner ids.
package bridge_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way winner select: round-robin on ties, or master 0 always wins a tie
// when BRIDGE_ARB_FIXED_PRIO_EN is defined.
module arb_rr2
    import bridge_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        // NOTE: default assignment first so every path drives winner (no latch).
        winner = OWN_M0;
        if (req == 2'b11) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
            winner = OWN_M0;
`else
            winner = ~last_grant;
`endif
        end else if (req[1]) begin
            winner = OWN_M1;
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Shares one bridge port between two masters: IDLE -> XFER -> DONE per access.
// Compile option BRIDGE_ARB_FIXED_PRIO_EN selects fixed priority (master 0) on ties.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    input  logic          m0_we,
    input  logic [BW-1:0] m0_be,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    input  logic          m1_we,
    input  logic [BW-1:0] m1_be,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd,
    output logic [AW-1:0] pr_addr,
    output logic [DW-1:0] pr_wd,
    output logic          pr_we,
    output logic [BW-1:0] pr_be,
    input  logic [DW-1:0] pr_rd,
    output logic          busy
);

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   winner;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wd;
    logic          sel_we;
    logic [BW-1:0] sel_be;

    arb_rr2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        sel_addr = m0_addr;
        sel_wd   = m0_wd;
        sel_we   = m0_we;
        sel_be   = m0_be;
        if (winner == OWN_M1) begin
            sel_addr = m1_addr;
            sel_wd   = m1_wd;
            sel_we   = m1_we;
            sel_be   = m1_be;
        end
    end

    // The pr_* registers double as the access latch: loaded in IDLE, shown
    // during XFER, cleared on leaving XFER so the bridge sees zeros otherwise.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_M0;
            last_grant <= OWN_M1;
            pr_addr    <= '0;
            pr_wd      <= '0;
            pr_we      <= 1'b0;
            pr_be      <= '0;
            m0_ack     <= 1'b0;
            m0_rd      <= '0;
            m1_ack     <= 1'b0;
            m1_rd      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner   <= winner;
                        pr_addr <= sel_addr;
                        pr_wd   <= sel_wd;
                        pr_we   <= sel_we;
                        pr_be   <= sel_be;
                        busy    <= 1'b1;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    last_grant <= owner;
                    pr_addr    <= '0;
                    pr_wd      <= '0;
                    pr_we      <= 1'b0;
                    pr_be      <= '0;
                    m0_ack     <= (owner == OWN_M0);
                    m0_rd      <= (owner == OWN_M0) ? pr_rd : '0;
                    m1_ack     <= (owner == OWN_M1);
                    m1_rd      <= (owner == OWN_M1) ? pr_rd : '0;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    m0_ack <= 1'b0;
                    m0_rd  <= '0;
                    m1_ack <= 1'b0;
                    m1_rd  <= '0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter with a transaction-level reference model.
module tb_bridge_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wd = '0, m1_wd = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_ack, m1_ack, pr_we, busy;
    logic [31:0] m0_rd, m1_rd, pr_addr, pr_wd, pr_rd;
    logic [3:0]  pr_be;

    int errors = 0;
    int checks = 0;

    bridge_arbiter #(.AW(32), .DW(32), .BW(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we), .m0_be(m0_be),
        .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we), .m1_be(m1_be),
        .m1_ack(m1_ack), .m1_rd(m1_rd),
        .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .pr_be(pr_be),
        .pr_rd(pr_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bridge stand-in: one known word, an unmapped hole returning 0, else an address-derived pattern.
    function automatic logic [31:0] bridge_rd(input logic [31:0] a);
        if (a == 32'h0000_7F04) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0100) return 32'h0;
        return {a[15:0], 16'hA5A5};
    endfunction

    assign pr_rd = bridge_rd(pr_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is "on the bridge" for one cycle then "acking" for one.
    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [3:0]  be;
    } txn_t;

    int          m_age;
    txn_t        m_txn;
    logic        m_last;
    logic [31:0] m_rd;

    function automatic txn_t pick();
        txn_t t;
        logic who;
        if (m0_req && m1_req) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
            who = 1'b0;
`else
            who = ~m_last;
`endif
        end else begin
            who = m1_req;
        end
        t.owner = who;
        t.addr  = who ? m1_addr : m0_addr;
        t.wd    = who ? m1_wd : m0_wd;
        t.we    = who ? m1_we : m0_we;
        t.be    = who ? m1_be : m0_be;
        return t;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age  <= 0;
            m_last <= 1'b1;
            m_rd   <= '0;
        end else if (m_age == 0) begin
            if (m0_req || m1_req) begin
                m_txn <= pick();
                m_age <= 1;
            end
        end else if (m_age == 1) begin
            m_rd   <= bridge_rd(m_txn.addr);
            m_last <= m_txn.owner;
            m_age  <= 2;
        end else begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic on_bus, a0, a1;
            on_bus = (m_age == 1);
            a0 = (m_age == 2) && !m_txn.owner;
            a1 = (m_age == 2) && m_txn.owner;
            check("cmp_pr_addr", pr_addr, on_bus ? m_txn.addr : 32'h0);
            check("cmp_pr_wd",   pr_wd,   on_bus ? m_txn.wd : 32'h0);
            check("cmp_pr_we",   {31'h0, pr_we}, {31'h0, on_bus & m_txn.we});
            check("cmp_pr_be",   {28'h0, pr_be}, {28'h0, on_bus ? m_txn.be : 4'h0});
            check("cmp_busy",    {31'h0, busy},   {31'h0, m_age != 0});
            check("cmp_m0_ack",  {31'h0, m0_ack}, {31'h0, a0});
            check("cmp_m1_ack",  {31'h0, m1_ack}, {31'h0, a1});
            check("cmp_m0_rd",   m0_rd, a0 ? m_rd : 32'h0);
            check("cmp_m1_rd",   m1_rd, a1 ? m_rd : 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] b);
        m0_req = r; m0_addr = a; m0_wd = d; m0_we = w; m0_be = b;
    endtask

    task automatic drive_m1(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] b);
        m1_req = r; m1_addr = a; m1_wd = d; m1_we = w; m1_be = b;
    endtask

    int   n_acks;
    logic order [4];
    logic exp_order [4];

    initial begin
        #1 reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_busy",    {31'h0, busy}, 32'h0);
        check("rst_pr_addr", pr_addr, 32'h0);
        check("rst_acks",    {30'h0, m1_ack, m0_ack}, 32'h0);

        // Single read by master 0
        drive_m0(1'b1, 32'h0000_7F04, 32'h0, 1'b0, 4'hF);
        step();
        check("rd_pr_addr", pr_addr, 32'h0000_7F04);
        check("rd_pr_we",   {31'h0, pr_we}, 32'h0);
        step();
        check("rd_m0_ack", {31'h0, m0_ack}, 32'h1);
        check("rd_m0_rd",  m0_rd, 32'hDEAD_BEEF);
        check("rd_m1_ack", {31'h0, m1_ack}, 32'h0);
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        check("rd_ack_gone", {31'h0, m0_ack}, 32'h0);

        // Single write by master 1
        drive_m1(1'b1, 32'h0000_7F10, 32'h1234_5678, 1'b1, 4'hF);
        step();
        check("wr_pr_we", {31'h0, pr_we}, 32'h1);
        check("wr_pr_wd", pr_wd, 32'h1234_5678);
        check("wr_pr_be", {28'h0, pr_be}, 32'hF);
        step();
        check("wr_pr_we_low", {31'h0, pr_we}, 32'h0);
        check("wr_m1_ack",    {31'h0, m1_ack}, 32'h1);
        drive_m1(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();

        // Both masters hold requests for four accesses
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        drive_m0(1'b1, 32'h0000_2000, 32'h0, 1'b0, 4'hF);
        drive_m1(1'b1, 32'h0000_3000, 32'h0, 1'b0, 4'h3);
        n_acks = 0;
        for (int cyc = 0; cyc < 40 && n_acks < 4; cyc++) begin
            step();
            if (m0_ack) begin order[n_acks] = 1'b0; n_acks++; end
            else if (m1_ack) begin order[n_acks] = 1'b1; n_acks++; end
        end
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        drive_m1(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        check("tie_ack_count", n_acks, 4);
        for (int i = 0; i < 4; i++)
            if (i < n_acks) check($sformatf("tie_order_%0d", i), {31'h0, order[i]}, {31'h0, exp_order[i]});
        step();

        // Unmapped read returns 0 and is still acked
        drive_m0(1'b1, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
        step();
        step();
        check("unm_m0_ack", {31'h0, m0_ack}, 32'h1);
        check("unm_m0_rd",  m0_rd, 32'h0);
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();

        // Reset during the XFER cycle of a write
        drive_m0(1'b1, 32'h0000_7F20, 32'hCAFE_F00D, 1'b1, 4'hC);
        step();
        check("rx_pr_we_before", {31'h0, pr_we}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rx_pr_we_async", {31'h0, pr_we}, 32'h0);
        check("rx_busy_async",  {31'h0, busy}, 32'h0);
        check("rx_pr_addr",     pr_addr, 32'h0);
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        reset = 1'b0;
        step();
        check("rx_no_ack", {31'h0, m0_ack}, 32'h0);
        drive_m0(1'b1, 32'h0000_7F04, 32'h0, 1'b0, 4'hF);
        step();
        step();
        check("rx_after_ack", {31'h0, m0_ack}, 32'h1);
        check("rx_after_rd",  m0_rd, 32'hDEAD_BEEF);
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();

        // Master 1 requests while master 0 is in XFER
        drive_m0(1'b1, 32'h0000_4444, 32'h0, 1'b0, 4'hF);
        step();
        drive_m1(1'b1, 32'h0000_5550, 32'h0, 1'b0, 4'h1);
        step();
        check("late_m0_ack", {31'h0, m0_ack}, 32'h1);
        check("late_m0_rd",  m0_rd, 32'h4444_A5A5);
        drive_m0(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        check("late_idle_busy", {31'h0, busy}, 32'h0);
        step();
        check("late_m1_addr", pr_addr, 32'h0000_5550);
        step();
        check("late_m1_ack", {31'h0, m1_ack}, 32'h1);
        check("late_m1_rd",  m1_rd, 32'h5550_A5A5);
        drive_m1(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
